// File: rtl/ram_pkg.sv
// ram_pkg: definitions shared by the RAM family.
// Holds the read-during-write mode constants, the clear/run state encoding
// and the byte-lane merge helper used wherever a partial-word write is
// folded into an existing word.
package ram_pkg;

  localparam int CRdwOld = 0;
  localparam int CRdwNew = 1;

  typedef enum logic {
    SClear = 1'b0,
    SRun   = 1'b1
  } ram_state_e;

  // Merge one byte lane. Callers loop over the lanes of their own word, so
  // the helper serves any word width that is a multiple of 8.
  function automatic logic [7:0] ByteMerge(input logic [7:0] old_lane,
                                           input logic [7:0] new_lane,
                                           input logic       mask);
    return mask ? new_lane : old_lane;
  endfunction

endpackage

// File: rtl/ram_sx_be_if.sv
// ram_sx_be_if: request/response bundle of the byte-enable RAM.
// master drives AAddr, AMosi, AByteEn, AWrEn, ARdEn and AClr and receives
// AMiso, AMisoVld and ABusy; slave is the RAM side of the same signals.
interface ram_sx_be_if #(
  parameter int CAddrLen = 10,
  parameter int CDataLen = 64
);

  logic [CAddrLen-1:0]   AAddr;
  logic [CDataLen-1:0]   AMosi;
  logic [CDataLen/8-1:0] AByteEn;
  logic                  AWrEn;
  logic                  ARdEn;
  logic                  AClr;
  logic [CDataLen-1:0]   AMiso;
  logic                  AMisoVld;
  logic                  ABusy;

  modport master (
    output AAddr, AMosi, AByteEn, AWrEn, ARdEn, AClr,
    input  AMiso, AMisoVld, ABusy
  );

  modport slave (
    input  AAddr, AMosi, AByteEn, AWrEn, ARdEn, AClr,
    output AMiso, AMisoVld, ABusy
  );

endinterface

// File: rtl/ram_sx_be_core.sv
// ram_sx_be_core: byte-lane storage array with a registered read port.
// Ports: clk (rising edge), en (clock enable, freezes array and read
// register), addr, wdata, byte_en (per-lane write mask), wr_en, rd_en,
// rdata (read register, updated only on enabled reads).
// No reset on purpose, so synthesis can map it onto block RAM.
module ram_sx_be_core
  import ram_pkg::*;
#(
  parameter int CAddrLen = 10,
  parameter int CDataLen = 64,
  parameter int CRdwMode = CRdwOld
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [CAddrLen-1:0]   addr,
  input  logic [CDataLen-1:0]   wdata,
  input  logic [CDataLen/8-1:0] byte_en,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [CDataLen-1:0]   rdata
);

  localparam int CBytes = CDataLen / 8;
  localparam int CDepth = 2 ** CAddrLen;

  logic [CDataLen-1:0] mem [CDepth];
  logic [CDataLen-1:0] read_word;

  // In new-data mode a colliding write is merged into the word on its way
  // to the read register; old-data mode falls out of the non-blocking write.
  generate
    if (CRdwMode == CRdwNew) begin : g_rdw_new
      always_comb begin
        read_word = mem[addr];
        if (wr_en) begin
          for (int i = 0; i < CBytes; i++) begin
            read_word[8*i +: 8] = ByteMerge(mem[addr][8*i +: 8], wdata[8*i +: 8], byte_en[i]);
          end
        end
      end
    end else begin : g_rdw_old
      assign read_word = mem[addr];
    end
  endgenerate

  // Guarded per-lane writes are the shape block-RAM inference recognises.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr_en) begin
        for (int i = 0; i < CBytes; i++) begin
          if (byte_en[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      if (rd_en) begin
        rdata <= read_word;
      end
    end
  end

endmodule

// File: rtl/ram_sx_be.sv
// ram_sx_be: single-port RAM with byte enables, clear sequencer and
// 1- or 2-cycle read pipeline.
// Ports: AClkH (clock), AResetH (async active-high reset), AClkHEn (clock
// enable for every register), bus (slave side of ram_sx_be_if).
// The clear FSM walks every address writing zero; while it runs, requests
// from the bus are dropped and ABusy is high.
module ram_sx_be
  import ram_pkg::*;
#(
  parameter int CAddrLen    = 10,
  parameter int CDataLen    = 64,
  parameter int CRdLat      = 1,
  parameter int CRdwMode    = CRdwOld,
  parameter int CClrOnReset = 1
) (
  input  logic         AClkH,
  input  logic         AResetH,
  input  logic         AClkHEn,
  ram_sx_be_if.slave   bus
);

  localparam logic [CAddrLen-1:0] CLastAddr = '1;
  localparam ram_state_e          CEntry    = (CClrOnReset != 0) ? SClear : SRun;

  ram_state_e            state, state_nxt;
  logic [CAddrLen-1:0]   clr_addr, clr_addr_nxt;
  logic                  core_wr, core_rd;
  logic [CAddrLen-1:0]   core_addr;
  logic [CDataLen-1:0]   core_wdata, core_rdata;
  logic [CDataLen/8-1:0] core_be;
  logic                  vld1, out_vld;
  logic [CDataLen-1:0]   out_data;

  // Clear FSM and request gating: in SClear the array port belongs to the
  // clear counter, in SRun it belongs to the bus.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    core_wr      = 1'b0;
    core_rd      = 1'b0;
    core_addr    = bus.AAddr;
    core_wdata   = bus.AMosi;
    core_be      = bus.AByteEn;
    unique case (state)
      SClear: begin
        core_wr      = 1'b1;
        core_addr    = clr_addr;
        core_wdata   = '0;
        core_be      = '1;
        clr_addr_nxt = clr_addr + CAddrLen'(1);
        if (clr_addr == CLastAddr) state_nxt = SRun;
      end
      SRun: begin
        core_wr = bus.AWrEn;
        core_rd = bus.ARdEn;
        if (bus.AClr) begin
          clr_addr_nxt = '0;
          state_nxt    = SClear;
        end
      end
    endcase
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state    <= CEntry;
      clr_addr <= '0;
    end else if (AClkHEn) begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  ram_sx_be_core #(
    .CAddrLen (CAddrLen),
    .CDataLen (CDataLen),
    .CRdwMode (CRdwMode)
  ) u_core (
    .clk     (AClkH),
    .en      (AClkHEn),
    .addr    (core_addr),
    .wdata   (core_wdata),
    .byte_en (core_be),
    .wr_en   (core_wr),
    .rd_en   (core_rd),
    .rdata   (core_rdata)
  );

  // First valid bit tracks the core read register.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) vld1 <= 1'b0;
    else if (AClkHEn) vld1 <= core_rd;
  end

  // Optional output register for timing closure; any value other than 2
  // gives the single-stage pipeline.
  generate
    if (CRdLat == 2) begin : g_lat2
      logic [CDataLen-1:0] data2;
      logic                vld2;
      always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
          data2 <= '0;
          vld2  <= 1'b0;
        end else if (AClkHEn) begin
          data2 <= core_rdata;
          vld2  <= vld1;
        end
      end
      assign out_data = data2;
      assign out_vld  = vld2;
    end else begin : g_lat1
      assign out_data = core_rdata;
      assign out_vld  = vld1;
    end
  endgenerate

  assign bus.AMiso    = out_data & {CDataLen{out_vld}};
  assign bus.AMisoVld = out_vld;
  assign bus.ABusy    = (state == SClear);

endmodule

// File: tb/tb_ram_sx_be.sv
// tb_ram_sx_be: two RAM instances (latency 1 / old-data, latency 2 /
// new-data) driven by the same stimulus and checked every cycle against a
// word-array model, plus literal expectations for the directed scenarios.
module tb_ram_sx_be;
  import ram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BE = DW / 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [BE-1:0] be    = '0;
  logic wr = 1'b0, rd = 1'b0, clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  ram_sx_be_if #(.CAddrLen(AW), .CDataLen(DW)) bus_a ();
  ram_sx_be_if #(.CAddrLen(AW), .CDataLen(DW)) bus_b ();

  assign bus_a.AAddr = addr;   assign bus_b.AAddr = addr;
  assign bus_a.AMosi = wdata;  assign bus_b.AMosi = wdata;
  assign bus_a.AByteEn = be;   assign bus_b.AByteEn = be;
  assign bus_a.AWrEn = wr;     assign bus_b.AWrEn = wr;
  assign bus_a.ARdEn = rd;     assign bus_b.ARdEn = rd;
  assign bus_a.AClr = clr;     assign bus_b.AClr = clr;

  ram_sx_be #(.CAddrLen(AW), .CDataLen(DW), .CRdLat(1), .CRdwMode(CRdwOld), .CClrOnReset(1))
    dut_a (.AClkH(clk), .AResetH(rst), .AClkHEn(en), .bus(bus_a));
  ram_sx_be #(.CAddrLen(AW), .CDataLen(DW), .CRdLat(2), .CRdwMode(CRdwNew), .CClrOnReset(1))
    dut_b (.AClkH(clk), .AResetH(rst), .AClkHEn(en), .bus(bus_b));

  always #5 clk = ~clk;

  // Reference model: plain word array, remaining-clear-cycles count and a
  // queue of read results per instance.
  logic [DW-1:0] m_mem [DEPTH];
  int            busy_left;
  logic          a_vld;
  logic [DW-1:0] a_data;
  logic          b_vld  [2];
  logic [DW-1:0] b_data [2];

  task automatic model_reset();
    busy_left = DEPTH;
    a_vld = 1'b0;  a_data = '0;
    b_vld[0] = 1'b0;  b_vld[1] = 1'b0;
    b_data[0] = '0;   b_data[1] = '0;
  endtask

  task automatic model_cycle();
    logic [DW-1:0] old_w, new_w;
    if (rst || !en) return;
    b_vld[1] = b_vld[0];
    b_data[1] = b_data[0];
    if (busy_left > 0) begin
      m_mem[DEPTH - busy_left] = '0;
      busy_left--;
      a_vld = 1'b0;     a_data = '0;
      b_vld[0] = 1'b0;  b_data[0] = '0;
    end else begin
      old_w = m_mem[addr];
      new_w = old_w;
      for (int i = 0; i < BE; i++) if (be[i]) new_w[8*i +: 8] = wdata[8*i +: 8];
      a_vld = rd;
      a_data = rd ? old_w : '0;
      b_vld[0] = rd;
      b_data[0] = rd ? (wr ? new_w : old_w) : '0;
      if (wr) m_mem[addr] = new_w;
      if (clr) busy_left = DEPTH;
    end
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic w, input logic r, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [BE-1:0] b, input logic c);
    wr = w;  rd = r;  addr = a;  wdata = d;  be = b;  clr = c;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_cycle();
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check_output("a_busy", 64'(bus_a.ABusy), 64'(busy_left > 0));
    check_output("a_vld", 64'(bus_a.AMisoVld), 64'(a_vld));
    check_output("a_miso", bus_a.AMiso, a_data);
    check_output("b_busy", 64'(bus_b.ABusy), 64'(busy_left > 0));
    check_output("b_vld", 64'(bus_b.AMisoVld), 64'(b_vld[1]));
    check_output("b_miso", bus_b.AMiso, b_data[1]);
  end

  logic [DW-1:0] vals [3];
  logic [DW-1:0] exp_b [5];
  logic          exp_v [5];
  int n;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    idle();
    step(); step();
    check_output("reset_busy", 64'(bus_a.ABusy), 64'd1);
    check_output("reset_vld", 64'(bus_b.AMisoVld), 64'd0);
    check_output("reset_miso", bus_a.AMiso, 64'd0);
    rst = 1'b0;

    // Clear after reset, with a write attempted in its first cycle.
    n = 0;
    apply_stimulus(1'b1, 1'b0, 4'd2, 64'hDEAD_BEEF_0000_1111, 8'hFF, 1'b0);
    while (bus_a.ABusy && n < 100) begin
      step();
      if (n == 0) idle();
      n++;
    end
    check_output("clear_len", 64'(n), 64'd16);
    for (int a = 0; a < DEPTH; a++) begin
      apply_stimulus(1'b0, 1'b1, 4'(a), '0, '0, 1'b0);
      step();
      check_output("post_clear_vld", 64'(bus_a.AMisoVld), 64'd1);
      check_output("post_clear_rd", bus_a.AMiso, 64'd0);
    end
    idle(); step(); step();

    // Partial write merge, then an all-zero mask write that must not change anything.
    apply_stimulus(1'b1, 1'b0, 4'd3, 64'h1122334455667788, 8'hFF, 1'b0); step();
    apply_stimulus(1'b1, 1'b0, 4'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0); step();
    apply_stimulus(1'b1, 1'b0, 4'd3, 64'h0, 8'h00, 1'b0); step();
    apply_stimulus(1'b0, 1'b1, 4'd3, '0, '0, 1'b0); step();
    check_output("merge_a", bus_a.AMiso, 64'h11223344AAAAAAAA);
    check_output("model_merge", a_data, 64'h11223344AAAAAAAA);
    idle(); step();
    check_output("merge_b", bus_b.AMiso, 64'h11223344AAAAAAAA);
    check_output("merge_a_vld_drop", 64'(bus_a.AMisoVld), 64'd0);

    // Same-cycle write and read of address 5.
    apply_stimulus(1'b1, 1'b1, 4'd5, '1, 8'hFF, 1'b0); step();
    check_output("rdw_old", bus_a.AMiso, 64'h0);
    idle(); step();
    check_output("rdw_new", bus_b.AMiso, 64'hFFFFFFFFFFFFFFFF);
    apply_stimulus(1'b0, 1'b1, 4'd5, '0, '0, 1'b0); step();
    check_output("rdw_next_a", bus_a.AMiso, 64'hFFFFFFFFFFFFFFFF);
    idle(); step();
    check_output("rdw_next_b", bus_b.AMiso, 64'hFFFFFFFFFFFFFFFF);

    // Latency-2 burst of three reads.
    vals[0] = 64'h1000_0000_0000_00A0;
    vals[1] = 64'h2000_0000_0000_00B1;
    vals[2] = 64'h3000_0000_0000_00C2;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 4'(k), vals[k], 8'hFF, 1'b0); step();
    end
    idle(); step();
    exp_b = '{64'h0, vals[0], vals[1], vals[2], 64'h0};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) apply_stimulus(1'b0, 1'b1, 4'(k), '0, '0, 1'b0);
      else idle();
      step();
      check_output("burst_vld", 64'(bus_b.AMisoVld), 64'(exp_v[k]));
      check_output("burst_data", bus_b.AMiso, exp_b[k]);
    end

    // Clock enable held low for 3 cycles with a latency-2 read in flight.
    apply_stimulus(1'b0, 1'b1, 4'd1, '0, '0, 1'b0); step();
    idle();
    check_output("stall_vld0", 64'(bus_b.AMisoVld), 64'd0);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("stall_hold", 64'(bus_b.AMisoVld), 64'd0);
    end
    check_output("stall_a_hold", bus_a.AMiso, vals[1]);
    en = 1'b1;
    step();
    check_output("stall_vld", 64'(bus_b.AMisoVld), 64'd1);
    check_output("stall_data", bus_b.AMiso, vals[1]);

    // Clear request in SRun, stretched by 3 disabled cycles.
    apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b1); step();
    idle();
    check_output("clr_busy_rise", 64'(bus_a.ABusy), 64'd1);
    n = 0;
    while (bus_a.ABusy && n < 100) begin
      en = !(n >= 5 && n < 8);
      step();
      n++;
    end
    en = 1'b1;
    check_output("clr_len_stretched", 64'(n), 64'd19);
    for (int a = 0; a < DEPTH; a++) begin
      apply_stimulus(1'b0, 1'b1, 4'(a), '0, '0, 1'b0);
      step();
      check_output("after_clr_rd", bus_a.AMiso, 64'd0);
    end
    idle(); step(); step();

    // Reset with a read in flight.
    apply_stimulus(1'b1, 1'b0, 4'd7, 64'h7777_7777_7777_7777, 8'hFF, 1'b0); step();
    apply_stimulus(1'b0, 1'b1, 4'd7, '0, '0, 1'b0); step();
    idle();
    check_output("pre_rst_vld", 64'(bus_a.AMisoVld), 64'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_output("rst_vld_a", 64'(bus_a.AMisoVld), 64'd0);
    check_output("rst_vld_b", 64'(bus_b.AMisoVld), 64'd0);
    check_output("rst_miso_a", bus_a.AMiso, 64'd0);
    step(); step();
    rst = 1'b0;

    // Reset midway through the clear; it must restart from address 0.
    for (int k = 0; k < 8; k++) step();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    n = 0;
    while (bus_a.ABusy && n < 100) begin
      step();
      n++;
    end
    check_output("clear_restart_len", 64'(n), 64'd16);

    // Randomised traffic checked by the per-cycle compare process.
    for (int k = 0; k < 2500; k++) begin
      en = ($urandom_range(0, 9) != 0);
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom),
                     {$urandom(), $urandom()}, BE'($urandom), ($urandom_range(0, 299) == 0));
      step();
    end
    en = 1'b1;
    idle();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
